// File: rtl/systolic_skew_feeder.sv
// Row-skewed west-edge feeder for a systolic array: snapshots the A matrix on start,
// then streams row i delayed by i cycles. Optional macro: SKEW_FEEDER_BACK_TO_BACK_EN.
module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 4,
  parameter int ARRAY_L    = 4
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             start,
  input  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]  data_rom,
  output logic [0:ARRAY_W-1][DATA_WIDTH-1:0]               out_a,
  output logic [0:ARRAY_W-1]                               out_valid,
  output logic                                             busy,
  output logic                                             done
);

  localparam int T  = ARRAY_L + ARRAY_W - 1;
  localparam int CW = $clog2(T + 1);

  typedef enum logic [1:0] {IDLE, FEED, DONE} state_t;

  state_t state, state_nx;

  logic [CW-1:0]                                    cnt, cnt_nx;
  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]  mat;
  logic                                             capture;
  logic                                             last;
  logic                                             chained, chained_nx;
  logic [0:ARRAY_W-1][DATA_WIDTH-1:0]               a_nx;
  logic [0:ARRAY_W-1]                               v_nx;
  logic                                             busy_nx, done_nx;

  assign last = (cnt == CW'(T - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          capture  = 1'b1;
          state_nx = FEED;
        end
      end
      FEED: begin
        if (last) begin
`ifdef SKEW_FEEDER_BACK_TO_BACK_EN
          if (start) capture = 1'b1;
          else       state_nx = DONE;
`else
          state_nx = DONE;
`endif
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_nx     = cnt;
    chained_nx = capture && (state == FEED);
    if (capture)            cnt_nx = '0;
    else if (state == FEED) cnt_nx = cnt + 1'b1;
  end

  // Next values of the registered outputs; the edge in FEED loads the wavefront for t=cnt.
  always_comb begin
    a_nx    = '0;
    v_nx    = '0;
    busy_nx = 1'b0;
    done_nx = 1'b0;
    if (state == FEED) begin
      busy_nx = 1'b1;
      done_nx = chained && (cnt == '0);
      for (int unsigned i = 0; i < ARRAY_W; i++) begin
        for (int unsigned j = 0; j < ARRAY_L; j++) begin
          if (cnt == CW'(i + j)) begin
            a_nx[i] = mat[i][j];
            v_nx[i] = 1'b1;
          end
        end
      end
    end else if (state == DONE) begin
      done_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      mat       <= '0;
      chained   <= 1'b0;
      out_a     <= '0;
      out_valid <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      chained   <= chained_nx;
      out_a     <= a_nx;
      out_valid <= v_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      if (capture) mat <= data_rom;
    end
  end

endmodule
